// File: rtl/udc_cfg_sequencer.sv
// udc_cfg_sequencer
// Bus-master controller that programs and launches the 8-bit up/down cycle
// counter. It accepts one configuration request and writes PLR/ULR/LLR/CCR
// over the counter's active-low chip-select/read/write bus. When asked, it
// reads the registers back to verify them. It then checks the counter's
// range error, pulses start for one clock and waits for end-of-cycle.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cfg_valid/ready     request handshake (ready only while idle)
//   cfg_plr..cfg_ccr    requested register values; verify_en enables readback
//   busy, done, status  progress / completion pulse / result code
//                       (00 ok, 01 readback mismatch, 10 range error, 11 timeout)
//   bus_ncs/nrd/nwr     counter bus strobes, active-low
//   bus_a, bus_dout     register address and write data
//   bus_doe             write-data drive enable for the shared Din lines
//   bus_din             Din lines as seen by the sequencer
//   dev_err, dev_ec     counter range error and end-of-cycle
//   dev_start           counter start pulse
module udc_cfg_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  input  logic       verify_en,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic       bus_ncs,
  output logic       bus_nrd,
  output logic       bus_nwr,
  output logic [1:0] bus_a,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  input  logic [7:0] bus_din,
  input  logic       dev_err,
  input  logic       dev_ec,
  output logic       dev_start
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRECHK, S_WR_SETUP, S_WR_STROBE, S_RD_SETUP,
    S_RD_SAMPLE, S_ERRCHK, S_START, S_WAIT_EC, S_DONE
  } state_t;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_MISMATCH = 2'b01;
  localparam logic [1:0] ST_RANGE    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  index_q, index_d;
  logic        phase_q, phase_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
  logic        verify_q, verify_d;
  logic [1:0]  status_q, status_d;
  logic        cfg_ready_q, busy_q, done_q, dev_start_q;
  logic        bus_ncs_q, bus_nrd_q, bus_nwr_q, bus_doe_q;
  logic [1:0]  bus_a_q;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic [7:0]  wr_data, rd_expect;

  // Latched register value for the next write and the current readback.
  always_comb begin
    wr_data   = plr_q;
    rd_expect = plr_q;
    case (index_d)
      2'd0:    wr_data = plr_q;
      2'd1:    wr_data = ulr_q;
      2'd2:    wr_data = llr_q;
      default: wr_data = ccr_q;
    endcase
    case (index_q)
      2'd0:    rd_expect = plr_q;
      2'd1:    rd_expect = ulr_q;
      2'd2:    rd_expect = llr_q;
      default: rd_expect = ccr_q;
    endcase
  end

  // Next-state logic. Outputs are derived from the next state so that each
  // registered output lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    phase_d    = phase_q;
    tmo_cnt_d  = tmo_cnt_q;
    plr_d      = plr_q;
    ulr_d      = ulr_q;
    llr_d      = llr_q;
    ccr_d      = ccr_q;
    verify_d   = verify_q;
    status_d   = status_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          plr_d    = cfg_plr;
          ulr_d    = cfg_ulr;
          llr_d    = cfg_llr;
          ccr_d    = cfg_ccr;
          verify_d = verify_en;
          state_d  = S_PRECHK;
        end
      end
      S_PRECHK: begin
        if ((plr_q < llr_q) || (plr_q > ulr_q)) begin
          status_d = ST_RANGE;
          state_d  = S_DONE;
        end else begin
          index_d = 2'd0;
          state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP: state_d = S_WR_STROBE;
      S_WR_STROBE: begin
        if (index_q != 2'd3) begin
          index_d = index_q + 2'd1;
          state_d = S_WR_SETUP;
        end else if (verify_q) begin
          index_d = 2'd0;
          state_d = S_RD_SETUP;
        end else begin
          phase_d = 1'b0;
          state_d = S_ERRCHK;
        end
      end
      S_RD_SETUP: state_d = S_RD_SAMPLE;
      S_RD_SAMPLE: begin
        if (bus_din != rd_expect) begin
          status_d = ST_MISMATCH;
          state_d  = S_DONE;
        end else if (index_q == 2'd3) begin
          phase_d = 1'b0;
          state_d = S_ERRCHK;
        end else begin
          index_d = index_q + 2'd1;
          state_d = S_RD_SETUP;
        end
      end
      // Two cycles so the counter's err output has settled after the last
      // access; only the second cycle's sample is trusted.
      S_ERRCHK: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (dev_err) begin
          status_d = ST_RANGE;
          state_d  = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_cnt_d = 16'd0;
        state_d   = S_WAIT_EC;
      end
      // End-of-cycle wins over a timeout expiring in the same cycle.
      S_WAIT_EC: begin
        if (dev_ec) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (tmo_cnt_q == TIMEOUT - 16'd1) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    bus_dout_d = bus_dout_q;
    if (state_d == S_WR_SETUP || state_d == S_WR_STROBE)
      bus_dout_d = wr_data;
  end

  // Single state register; synchronous reset forces every strobe inactive
  // on the same edge, even in the middle of a write or the end-of-cycle wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= 2'd0;
      phase_q     <= 1'b0;
      tmo_cnt_q   <= 16'd0;
      plr_q       <= 8'd0;
      ulr_q       <= 8'd0;
      llr_q       <= 8'd0;
      ccr_q       <= 8'd0;
      verify_q    <= 1'b0;
      status_q    <= ST_OK;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dev_start_q <= 1'b0;
      bus_ncs_q   <= 1'b1;
      bus_nrd_q   <= 1'b1;
      bus_nwr_q   <= 1'b1;
      bus_doe_q   <= 1'b0;
      bus_a_q     <= 2'd0;
      bus_dout_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      phase_q     <= phase_d;
      tmo_cnt_q   <= tmo_cnt_d;
      plr_q       <= plr_d;
      ulr_q       <= ulr_d;
      llr_q       <= llr_d;
      ccr_q       <= ccr_d;
      verify_q    <= verify_d;
      status_q    <= status_d;
      cfg_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      dev_start_q <= (state_d == S_START);
      // Chip select stays low from the first write through the end-of-cycle
      // wait because the counter only counts while selected.
      bus_ncs_q   <= (state_d == S_IDLE) || (state_d == S_PRECHK) || (state_d == S_DONE);
      bus_nrd_q   <= !((state_d == S_RD_SETUP) || (state_d == S_RD_SAMPLE));
      bus_nwr_q   <= (state_d != S_WR_STROBE);
      bus_doe_q   <= (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE);
      bus_a_q     <= index_d;
      bus_dout_q  <= bus_dout_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;
  assign dev_start = dev_start_q;
  assign bus_ncs   = bus_ncs_q;
  assign bus_nrd   = bus_nrd_q;
  assign bus_nwr   = bus_nwr_q;
  assign bus_doe   = bus_doe_q;
  assign bus_a     = bus_a_q;
  assign bus_dout  = bus_dout_q;

endmodule

// File: tb/tb_udc_cfg_sequencer.sv
// Self-checking bench for udc_cfg_sequencer. A small counter-register model
// captures bus writes and answers reads. A scoreboard queue holds the
// expected {address, data} writes pushed when each request is driven. The
// queue is popped whenever the DUT strobes a write.
module tb_udc_cfg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
  logic       verify_en;
  logic       busy, done;
  logic [1:0] status;
  logic       bus_ncs, bus_nrd, bus_nwr, bus_doe;
  logic [1:0] bus_a;
  logic [7:0] bus_dout, bus_din;
  logic       dev_err, dev_ec, dev_start;

  int n_checks = 0;
  int n_fails  = 0;

  logic [9:0] exp_q[$];
  logic [7:0] dev_regs[4];
  bit         corrupt_ulr = 1'b0;

  udc_cfg_sequencer #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .verify_en(verify_en), .busy(busy), .done(done), .status(status),
    .bus_ncs(bus_ncs), .bus_nrd(bus_nrd), .bus_nwr(bus_nwr),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
    .dev_err(dev_err), .dev_ec(dev_ec), .dev_start(dev_start)
  );

  always #5 clk = ~clk;

  // Counter register model, optionally corrupting the ULR readback.
  always_comb begin
    bus_din = dev_regs[bus_a];
    if (corrupt_ulr && bus_a == 2'd1) bus_din = 8'h07;
  end

  // Write monitor and strobe protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    n_checks++;
    if ((!bus_nwr && !bus_nrd) || (bus_doe && !bus_nrd)) begin
      n_fails++;
      $display("[TB] FAIL strobe_protocol: nwr=%b nrd=%b doe=%b, required no overlap", bus_nwr, bus_nrd, bus_doe);
    end
    if (bus_nwr === 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("[TB] FAIL unexpected_write: a=%0d d=%h with no write expected", bus_a, bus_dout);
      end else begin
        logic [9:0] exp;
        exp = exp_q.pop_front();
        if ({bus_a, bus_dout} !== exp || bus_ncs !== 1'b0 || bus_doe !== 1'b1) begin
          n_fails++;
          $display("[TB] FAIL write_data: got a=%0d d=%h ncs=%b doe=%b, required a=%0d d=%h ncs=0 doe=1",
                   bus_a, bus_dout, bus_ncs, bus_doe, exp[9:8], exp[7:0]);
        end
      end
      dev_regs[bus_a] = bus_dout;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one request and follows it to done. Cycle k counts negedges after
  // the accept edge. ec_delay < 0 leaves dev_ec low.
  task automatic run_request(input logic [7:0] plr, ulr, llr, ccr, input bit ver,
                             input int ec_delay, output int done_cyc, output int start_cyc,
                             output int start_cnt, output logic [1:0] st, output bit ncs_low);
    int k;
    done_cyc = -1; start_cyc = -1; start_cnt = 0; st = 2'b00; ncs_low = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL cfg_ready_idle: got %b, required 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_plr = plr; cfg_ulr = ulr; cfg_llr = llr; cfg_ccr = ccr; verify_en = ver;
    if (!(plr < llr || plr > ulr)) begin
      exp_q.push_back({2'd0, plr});
      exp_q.push_back({2'd1, ulr});
      exp_q.push_back({2'd2, llr});
      exp_q.push_back({2'd3, ccr});
    end
    @(negedge clk);
    k = 1;
    cfg_valid = 1'b0;
    cfg_plr = 8'($urandom); cfg_ulr = 8'($urandom);
    cfg_llr = 8'($urandom); cfg_ccr = 8'($urandom);
    verify_en = 1'($urandom);
    while (k <= 300) begin
      if (dev_start === 1'b1) begin
        start_cnt++;
        if (start_cyc < 0) start_cyc = k;
      end
      if (bus_ncs === 1'b0) ncs_low = 1'b1;
      if (done === 1'b1) begin
        done_cyc = k;
        st = status;
        break;
      end
      dev_ec = (ec_delay >= 0 && start_cyc >= 0 && k >= start_cyc + ec_delay);
      @(negedge clk);
      k++;
    end
    dev_ec = 1'b0;
    n_checks++;
    if (done_cyc < 0) begin
      n_fails++;
      $display("[TB] FAIL done_wait: no done within 300 cycles, required a done pulse");
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL writes_missing: %0d expected writes not seen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cfg_ready, busy, done, status, bus_ncs, bus_nrd, bus_nwr, bus_a, bus_dout, bus_doe, dev_start}
        !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL reset_values: got rdy=%b busy=%b done=%b st=%b ncs=%b nrd=%b nwr=%b a=%0d d=%h doe=%b start=%b, required 1 0 0 00 1 1 1 0 00 0 0",
               cfg_ready, busy, done, status, bus_ncs, bus_nrd, bus_nwr, bus_a, bus_dout, bus_doe, dev_start);
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    run_request(8'd5, 8'd8, 8'd2, 8'd1, 1'b0, 3, dc, sc, scnt, st, nl);
    n_checks++;
    if (sc !== 12 || scnt !== 1) begin
      n_fails++;
      $display("[TB] FAIL nominal_start: got cycle %0d count %0d, required cycle 12 count 1", sc, scnt);
    end
    n_checks++;
    if (dc !== 16 || st !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL nominal_done: got cycle %0d status %b, required cycle 16 status 00", dc, st);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 || status !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL nominal_after_done: got done=%b rdy=%b busy=%b st=%b, required 0 1 0 00", done, cfg_ready, busy, status);
    end
  endtask

  task automatic test_verify_ok;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    run_request(8'd3, 8'd9, 8'd1, 8'd4, 1'b1, 2, dc, sc, scnt, st, nl);
    n_checks++;
    if (sc !== 20 || dc !== 23 || st !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL verify_ok: got start %0d done %0d status %b, required 20 23 00", sc, dc, st);
    end
  endtask

  task automatic test_verify_mismatch;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    corrupt_ulr = 1'b1;
    run_request(8'd5, 8'd8, 8'd2, 8'd1, 1'b1, 1, dc, sc, scnt, st, nl);
    corrupt_ulr = 1'b0;
    n_checks++;
    if (dc !== 14 || st !== 2'b01 || scnt !== 0) begin
      n_fails++;
      $display("[TB] FAIL verify_mismatch: got done %0d status %b starts %0d, required 14 01 0", dc, st, scnt);
    end
  endtask

  task automatic test_precheck;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    run_request(8'd1, 8'd9, 8'd4, 8'd3, 1'b0, 1, dc, sc, scnt, st, nl);
    n_checks++;
    if (dc !== 2 || st !== 2'b10 || nl !== 1'b0 || scnt !== 0) begin
      n_fails++;
      $display("[TB] FAIL precheck_range: got done %0d status %b ncs_low %b starts %0d, required 2 10 0 0", dc, st, nl, scnt);
    end
    run_request(8'd10, 8'd9, 8'd4, 8'd3, 1'b0, 1, dc, sc, scnt, st, nl);
    n_checks++;
    if (dc !== 2 || st !== 2'b10 || nl !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL precheck_above_ulr: got done %0d status %b ncs_low %b, required 2 10 0", dc, st, nl);
    end
  endtask

  task automatic test_ccr_zero;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    run_request(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 1, dc, sc, scnt, st, nl);
    n_checks++;
    if (sc !== 12 || dc !== 14 || st !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL ccr_zero: got start %0d done %0d status %b, required 12 14 00", sc, dc, st);
    end
  endtask

  task automatic test_dev_err;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    dev_err = 1'b1;
    run_request(8'd5, 8'd8, 8'd2, 8'd1, 1'b0, 1, dc, sc, scnt, st, nl);
    dev_err = 1'b0;
    n_checks++;
    if (dc !== 12 || st !== 2'b10 || scnt !== 0) begin
      n_fails++;
      $display("[TB] FAIL dev_err: got done %0d status %b starts %0d, required 12 10 0", dc, st, scnt);
    end
  endtask

  task automatic test_timeout;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    run_request(8'd5, 8'd8, 8'd2, 8'd1, 1'b0, -1, dc, sc, scnt, st, nl);
    n_checks++;
    if (dc !== 33 || st !== 2'b11 || bus_ncs !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL timeout_done: got done %0d status %b ncs %b, required 33 11 1", dc, st, bus_ncs);
    end
    @(negedge clk);
    n_checks++;
    if (cfg_ready !== 1'b1 || status !== 2'b11) begin
      n_fails++;
      $display("[TB] FAIL timeout_idle: got rdy %b status %b, required 1 11", cfg_ready, status);
    end
  endtask

  task automatic test_back_to_back;
    int dc, sc, scnt; logic [1:0] st; bit nl;
    run_request(8'd4, 8'd6, 8'd4, 8'd2, 1'b0, 1, dc, sc, scnt, st, nl);
    n_checks++;
    if (dc !== 14 || st !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL b2b_first: got done %0d status %b, required 14 00", dc, st);
    end
    run_request(8'd6, 8'd6, 8'd6, 8'd7, 1'b1, 4, dc, sc, scnt, st, nl);
    n_checks++;
    if (sc !== 20 || dc !== 25 || st !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL b2b_second: got start %0d done %0d status %b, required 20 25 00", sc, dc, st);
    end
  endtask

  task automatic test_reset_mid_write;
    bit nl;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_plr = 8'd5; cfg_ulr = 8'd8; cfg_llr = 8'd2; cfg_ccr = 8'd1; verify_en = 1'b0;
    exp_q.push_back({2'd0, 8'd5});
    exp_q.push_back({2'd1, 8'd8});
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({cfg_ready, busy, done, status, bus_ncs, bus_nrd, bus_nwr, bus_a, bus_dout, bus_doe, dev_start}
        !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL reset_mid_values: got rdy=%b busy=%b done=%b st=%b ncs=%b nrd=%b nwr=%b a=%0d d=%h doe=%b start=%b, required 1 0 0 00 1 1 1 0 00 0 0",
               cfg_ready, busy, done, status, bus_ncs, bus_nrd, bus_nwr, bus_a, bus_dout, bus_doe, dev_start);
    end
    nl = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus_ncs === 1'b0) nl = 1'b1;
    end
    n_checks++;
    if (exp_q.size() != 0 || nl !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_mid_quiet: pending writes %0d ncs_low %b, required 0 0", exp_q.size(), nl);
    end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; verify_en = 1'b0;
    cfg_plr = 8'd0; cfg_ulr = 8'd0; cfg_llr = 8'd0; cfg_ccr = 8'd0;
    dev_err = 1'b0; dev_ec = 1'b0;
    test_reset;
    test_nominal;
    test_verify_ok;
    test_verify_mismatch;
    test_precheck;
    test_ccr_zero;
    test_dev_err;
    test_timeout;
    test_back_to_back;
    test_reset_mid_write;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/udc_cfg_sequencer.md
# udc_cfg_sequencer

Bus-master controller that programs and launches the 8-bit up/down cycle counter peripheral. It accepts one configuration request: preload, upper limit, lower limit and cycle count. It then writes the four counter registers over the counter's chip-select/read/write bus, optionally reads them back to verify, checks the counter's range error, pulses start and waits for end-of-cycle. It sits between a host or test FSM and the counter, and owns the counter's bus and start input exclusively.

## Interface
Parameters:
- TIMEOUT, 16'd65535, maximum clk cycles spent in WAIT_EC before reporting a timeout; legal range 1..65535.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  high only in IDLE; a transfer occurs when cfg_valid && cfg_ready at a rising edge.
- cfg_plr, cfg_ulr, cfg_llr, cfg_ccr  in  8 each  requested PLR/ULR/LLR/CCR values.
- verify_en  in  1  sampled with the request; 1 enables the readback phase.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse when a request completes.
- status  out  2  00 ok, 01 readback mismatch, 10 range error, 11 timeout; valid from done, held until next accept.
- bus_ncs, bus_nrd, bus_nwr  out  1 each  counter bus strobes, active-low.
- bus_a  out  2  register address {A1,A0}: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
- bus_dout  out  8  write data.
- bus_doe  out  1  1 = bus_dout drives the shared Din lines; top level builds the tristate.
- bus_din  in  8  Din lines as seen by the sequencer.
- dev_err, dev_ec  in  1 each  counter err and ec outputs.
- dev_start  out  1  counter start_in.

## Operation
- All outputs are registered.
- Reset values: cfg_ready=1, busy=0, done=0, status=00, bus_ncs=1, bus_nrd=1, bus_nwr=1, bus_a=00, bus_dout=00, bus_doe=0, dev_start=0.
- Reset asserted in any state returns to IDLE with the reset values on the next edge, mid-write and mid-WAIT_EC included. No partial strobe may extend past that edge.
- On accept, the request fields and verify_en are latched into internal registers. Later changes on cfg_* are ignored until the next accept.
- The FSM states are IDLE, PRECHK, WR_SETUP, WR_STROBE, RD_SETUP, RD_SAMPLE, ERRCHK, START, WAIT_EC and DONE.
- A 2-bit index selects the register: PLR, ULR, LLR, CCR, in ascending address order.
- PRECHK (1 cycle):
  - If plr<llr or plr>ulr (unsigned), go to DONE with status 10 and no bus activity.
  - Otherwise go to WR_SETUP with index 0.
- WR_SETUP (1 cycle): bus_ncs=0, bus_nwr=1, bus_a=index, bus_dout=reg[index], bus_doe=1.
- WR_STROBE (1 cycle): same as WR_SETUP but bus_nwr=0.
  - Index < 3: increment index and return to WR_SETUP.
  - Index = 3: go to RD_SETUP with index 0 if verify_en, else ERRCHK.
- RD_SETUP (1 cycle): bus_nrd=0, bus_nwr=1, bus_doe=0, bus_a=index.
- RD_SAMPLE (1 cycle): bus_nrd stays 0. bus_din is compared with reg[index] at the end of the cycle.
  - Mismatch: go to DONE with status 01.
  - Index = 3 and all registers match: go to ERRCHK.
- ERRCHK (2 cycles): strobes are inactive and bus_ncs stays 0. dev_err is sampled on the second cycle; 1 goes to DONE with status 10.
- START (1 cycle): dev_start=1 for exactly one clk period, never longer. The counter requires a 1-2 half-cycle start pulse.
- WAIT_EC: the timeout counter runs from 0.
  - dev_ec=1 goes to DONE with status 00.
  - Count reaching TIMEOUT goes to DONE with status 11.
- DONE (1 cycle): done=1 and bus_ncs=1. The next state is IDLE.
- bus_ncs is held 0 continuously from the first WR_SETUP through WAIT_EC, because the counter only counts while selected. It returns to 1 in DONE.
- bus_nwr and bus_nrd are never low in the same cycle. bus_doe is 1 only in WR_SETUP and WR_STROBE.
- cfg_ccr=0 is legal: the counter raises ec right after start, giving status 00.

## Timing
- Accept edge = T. Without verify_en:
  - PRECHK at T+1.
  - Writes T+2..T+9.
  - ERRCHK T+10..T+11.
  - START T+12.
  - WAIT_EC from T+13.
  - done the cycle after dev_ec is sampled high.
- verify_en adds 8 cycles (reads T+10..T+17, ERRCHK T+18..T+19, START T+20).
- PRECHK failure: done at T+2.
- A dev_ec high outside WAIT_EC is ignored.
- cfg_ready returns to 1 the cycle after DONE. Back-to-back requests are accepted with one idle cycle minimum.

## Test plan
- Reset mid-operation: assert reset during the T+5 WR_STROBE -> next edge shows all reset values, and the counter registers are not written again.
- Nominal run: PLR=5, ULR=8, LLR=2, CCR=1, verify_en=0 -> write sequence 00/05, 01/08, 10/02, 11/01. dev_start is high for one cycle at T+12. Done with status 00 after ec; the counter produces 5,6,7,8,7,...,2,...,5.
- Readback verify: verify_en=1 with a bench model that corrupts the ULR read to 0x07 -> status 01, and dev_start never rises.
- Local range pre-check: PLR=1, LLR=4, ULR=9 -> done at T+2, status 10, bus_ncs never low.
- CCR=0: PLR=0, ULR=3, LLR=0 -> ec almost immediately after start, status 00.
- Timeout: TIMEOUT=20 with dev_ec tied 0 -> status 11 exactly 20 cycles into WAIT_EC, then bus_ncs=1 and cfg_ready=1.
